// File: rtl/tb_dina_seq.sv
// Row-transfer sequencer feeding temp-buffer port A from the CB read port or the non-linear unit.
// State table:
//   IDLE  | waiting for a command, cmd_ready high
//   ISSUE | issuing CB reads or non-linear handshakes, one row per issue
//   DRAIN | all rows issued, waiting for the write pipeline to empty
//   DONE  | one-cycle completion pulse, mux select returned to 000
module tb_dina_seq #(
  parameter int ROW_W     = 8,
  parameter int CB_AW     = 10,
  parameter int TB_AW     = 10,
  parameter int CB_RD_LAT = 1
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_src,
  input  logic [1:0]       cmd_dir,
  input  logic             cmd_l_k0,
  input  logic [ROW_W-1:0] cmd_rows,
  input  logic [CB_AW-1:0] cmd_cb_addr,
  input  logic [TB_AW-1:0] cmd_tb_addr,
  output logic             CB_ena,
  output logic [CB_AW-1:0] CB_addra,
  input  logic             nl_valid,
  output logic             nl_ready,
  output logic [2:0]       TB_dina_sel,
  output logic             l_k_0,
  output logic             TB_ena,
  output logic             TB_wea,
  output logic [TB_AW-1:0] TB_addra,
  output logic             busy,
  output logic             done
);

  localparam int P = CB_RD_LAT + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             src_q;
  logic [ROW_W-1:0] rows_q;
  logic [ROW_W-1:0] issued_q;
  logic [CB_AW-1:0] cb_base_q;
  logic [TB_AW-1:0] tb_base_q;
  logic [P-1:0]     pv;
  logic [ROW_W-1:0] pidx [P-1];
  logic             fire, last, go;

  assign go   = cmd_valid && (cmd_rows != '0) && (cmd_dir != 2'b00);
  assign fire = (state == ISSUE) && (src_q ? nl_valid : 1'b1);
  assign last = (issued_q == rows_q - ROW_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = go ? ISSUE : DONE;
      ISSUE:   if (fire && last) state_nxt = DRAIN;
      // Anything left only in the last stage is being written this cycle.
      DRAIN:   if (!(|pv[P-2:0])) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign CB_ena    = (state == ISSUE) && !src_q;
  assign nl_ready  = (state == ISSUE) && src_q;
  assign CB_addra  = cb_base_q + CB_AW'(issued_q);
  assign TB_ena    = pv[P-1];
  assign TB_wea    = pv[P-1];

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      src_q       <= 1'b0;
      rows_q      <= '0;
      issued_q    <= '0;
      cb_base_q   <= '0;
      tb_base_q   <= '0;
      TB_dina_sel <= 3'b000;
      l_k_0       <= 1'b0;
      TB_addra    <= '0;
      pv          <= '0;
      for (int k = 0; k < P - 1; k++) pidx[k] <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && cmd_valid) begin
        src_q       <= cmd_src;
        rows_q      <= cmd_rows;
        cb_base_q   <= cmd_cb_addr;
        tb_base_q   <= cmd_tb_addr;
        issued_q    <= '0;
        TB_dina_sel <= go ? {cmd_src, cmd_dir} : 3'b000;
        l_k_0       <= go ? cmd_l_k0 : 1'b0;
      end else if (state_nxt == DONE) begin
        TB_dina_sel <= 3'b000;
        l_k_0       <= 1'b0;
      end

      if (fire) issued_q <= issued_q + ROW_W'(1);

      // CB rows enter at stage 0 to cover read latency; non-linear rows enter the last stage.
      pv[0]   <= fire && !src_q;
      pidx[0] <= issued_q;
      for (int k = 1; k < P - 1; k++) begin
        pv[k]   <= pv[k-1];
        pidx[k] <= pidx[k-1];
      end
      pv[P-1] <= pv[P-2] || (fire && src_q);

      if (pv[P-2])
        TB_addra <= tb_base_q + TB_AW'(pidx[P-2]);
      else if (fire && src_q)
        TB_addra <= tb_base_q + TB_AW'(issued_q);
    end
  end

endmodule

// File: tb/tb_tb_dina_seq.sv
// Scoreboard bench for tb_dina_seq: two instances (CB_RD_LAT 1 and 3), one monitored at a time.
module tb_tb_dina_seq;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_src = 1'b0, cmd_l_k0 = 1'b0, nl_valid = 1'b0;
  logic [1:0] cmd_dir = 2'b00;
  logic [7:0] cmd_rows = '0;
  logic [9:0] cmd_cb_addr = '0, cmd_tb_addr = '0;
  logic       use3 = 1'b0;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_ready, a_cb_ena, a_nl_ready, a_lk, a_tb_ena, a_tb_wea, a_busy, a_done;
  logic       b_ready, b_cb_ena, b_nl_ready, b_lk, b_tb_ena, b_tb_wea, b_busy, b_done;
  logic [9:0] a_cb_addra, a_tb_addra, b_cb_addra, b_tb_addra;
  logic [2:0] a_sel, b_sel;

  tb_dina_seq #(.ROW_W(8), .CB_AW(10), .TB_AW(10), .CB_RD_LAT(1)) dut1 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid && !use3), .cmd_ready(a_ready),
    .cmd_src(cmd_src), .cmd_dir(cmd_dir), .cmd_l_k0(cmd_l_k0), .cmd_rows(cmd_rows),
    .cmd_cb_addr(cmd_cb_addr), .cmd_tb_addr(cmd_tb_addr), .CB_ena(a_cb_ena),
    .CB_addra(a_cb_addra), .nl_valid(nl_valid), .nl_ready(a_nl_ready), .TB_dina_sel(a_sel),
    .l_k_0(a_lk), .TB_ena(a_tb_ena), .TB_wea(a_tb_wea), .TB_addra(a_tb_addra),
    .busy(a_busy), .done(a_done));

  tb_dina_seq #(.ROW_W(8), .CB_AW(10), .TB_AW(10), .CB_RD_LAT(3)) dut3 (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid && use3), .cmd_ready(b_ready),
    .cmd_src(cmd_src), .cmd_dir(cmd_dir), .cmd_l_k0(cmd_l_k0), .cmd_rows(cmd_rows),
    .cmd_cb_addr(cmd_cb_addr), .cmd_tb_addr(cmd_tb_addr), .CB_ena(b_cb_ena),
    .CB_addra(b_cb_addra), .nl_valid(nl_valid), .nl_ready(b_nl_ready), .TB_dina_sel(b_sel),
    .l_k_0(b_lk), .TB_ena(b_tb_ena), .TB_wea(b_tb_wea), .TB_addra(b_tb_addra),
    .busy(b_busy), .done(b_done));

  wire       m_ready    = use3 ? b_ready    : a_ready;
  wire       m_cb_ena   = use3 ? b_cb_ena   : a_cb_ena;
  wire       m_nl_ready = use3 ? b_nl_ready : a_nl_ready;
  wire       m_lk       = use3 ? b_lk       : a_lk;
  wire       m_tb_ena   = use3 ? b_tb_ena   : a_tb_ena;
  wire       m_tb_wea   = use3 ? b_tb_wea   : a_tb_wea;
  wire       m_busy     = use3 ? b_busy     : a_busy;
  wire       m_done     = use3 ? b_done     : a_done;
  wire [9:0] m_cb_addra = use3 ? b_cb_addra : a_cb_addra;
  wire [9:0] m_tb_addra = use3 ? b_tb_addra : a_tb_addra;
  wire [2:0] m_sel      = use3 ? b_sel      : a_sel;

  typedef struct {int cyc; logic [31:0] val;} ev_t;
  typedef struct {int s; int e; logic [2:0] sel; logic lk;} win_t;
  ev_t  rd_q[$], wr_q[$], hs_q[$], done_q[$];
  win_t win_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t ev;
    if (sys_rst) begin
      if (m_cb_ena) begin
        if (rd_q.size() == 0) check_eq("rd_unexp", m_cb_ena, 0);
        else begin
          ev = rd_q.pop_front();
          check_eq("rd_cyc", cyc, ev.cyc);
          check_eq("rd_addr", m_cb_addra, ev.val);
        end
      end
      if (m_nl_ready && nl_valid) begin
        if (hs_q.size() == 0) check_eq("hs_unexp", m_nl_ready, 0);
        else begin
          ev = hs_q.pop_front();
          check_eq("hs_cyc", cyc, ev.cyc);
        end
      end
      if (m_tb_wea) begin
        if (wr_q.size() == 0) check_eq("wr_unexp", m_tb_wea, 0);
        else begin
          ev = wr_q.pop_front();
          check_eq("wr_cyc", cyc, ev.cyc);
          check_eq("wr_addr", m_tb_addra, ev.val);
          check_eq("wr_ena", m_tb_ena, 1);
        end
      end
      if (m_done) begin
        check_eq("done_sel", {m_sel, m_lk}, 0);
        if (done_q.size() == 0) check_eq("done_unexp", m_done, 0);
        else begin
          ev = done_q.pop_front();
          check_eq("done_cyc", cyc, ev.cyc);
        end
      end
      while (win_q.size() != 0 && cyc > win_q[0].e) void'(win_q.pop_front());
      if (win_q.size() != 0 && cyc >= win_q[0].s)
        check_eq("sel_lk", {m_sel, m_lk}, {win_q[0].sel, win_q[0].lk});
    end
  end

  // Expected reads, handshakes, writes, done and select window for a command accepted in cycle a.
  task automatic push_expect(input int a, input logic src, input logic [1:0] dir, input logic lk,
                             input int rows, input logic [9:0] cb, input logic [9:0] tb,
                             input logic [15:0] pat, input int plen, output int d);
    int e, lat, k, i;
    logic [9:0] ad;
    e   = a + 1;
    lat = use3 ? 3 : 1;
    if (rows == 0 || dir == 2'b00) d = a + 1;
    else if (!src) begin
      for (k = 0; k < rows; k++) begin
        ad = cb + 10'(k);
        rd_q.push_back('{e + k, 32'(ad)});
        ad = tb + 10'(k);
        wr_q.push_back('{e + k + lat + 1, 32'(ad)});
      end
      d = e + rows + lat + 1;
    end else begin
      k = 0;
      i = 0;
      while (k < rows) begin
        if (i >= plen || pat[i]) begin
          hs_q.push_back('{e + i, 32'(k)});
          ad = tb + 10'(k);
          wr_q.push_back('{e + i + 1, 32'(ad)});
          k++;
        end
        i++;
      end
      d = e + i + 1;
    end
    done_q.push_back('{d, 32'd1});
    if (rows != 0 && dir != 2'b00) win_q.push_back('{e, d - 1, {src, dir}, lk});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", m_ready, 1);
  endtask

  task automatic drive(input logic src, input logic [1:0] dir, input logic lk, input int rows,
                       input logic [9:0] cb, input logic [9:0] tb);
    cmd_src     = src;
    cmd_dir     = dir;
    cmd_l_k0    = lk;
    cmd_rows    = 8'(rows);
    cmd_cb_addr = cb;
    cmd_tb_addr = tb;
    cmd_valid   = 1'b1;
  endtask

  task automatic send(input logic src, input logic [1:0] dir, input logic lk, input int rows,
                      input logic [9:0] cb, input logic [9:0] tb,
                      input logic [15:0] pat, input int plen);
    int a, d, i;
    wait_ready();
    drive(src, dir, lk, rows, cb, tb);
    a = cyc;
    push_expect(a, src, dir, lk, rows, cb, tb, pat, plen, d);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    i = 0;
    while (cyc <= d + 1) begin
      nl_valid = src ? ((i < plen) ? pat[i] : 1'b1) : 1'b0;
      @(posedge clk);
      #1;
      i++;
    end
    nl_valid = 1'b0;
  endtask

  initial begin
    int a, d1, d2;
    #12;
    check_eq("rst_ctl", {m_cb_ena, m_nl_ready, m_tb_ena, m_tb_wea, m_busy, m_done, m_lk, m_ready}, 8'h01);
    check_eq("rst_sel", m_sel, 0);
    check_eq("rst_addr", {m_cb_addra, m_tb_addra}, 0);
    @(negedge clk);
    sys_rst = 1'b1;

    send(1'b0, 2'b01, 1'b0, 4, 10'h010, 10'h020, 16'h0, 0);
    send(1'b1, 2'b10, 1'b0, 3, 10'h000, 10'h030, 16'h0019, 5);

    wait_ready();
    drive(1'b0, 2'b11, 1'b1, 2, 10'h040, 10'h080);
    a = cyc;
    push_expect(a, 1'b0, 2'b11, 1'b1, 2, 10'h040, 10'h080, 16'h0, 0, d1);
    @(posedge clk);
    #1 drive(1'b0, 2'b11, 1'b0, 2, 10'h050, 10'h090);
    push_expect(d1 + 1, 1'b0, 2'b11, 1'b0, 2, 10'h050, 10'h090, 16'h0, 0, d2);
    while (cyc < d1 + 1) begin
      @(negedge clk);
      if (cyc <= d1) check_eq("ready_busy", m_ready, 0);
    end
    check_eq("ready_after_done", m_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (cyc <= d2 + 1) @(posedge clk);

    send(1'b0, 2'b01, 1'b0, 0, 10'h060, 10'h0A0, 16'h0, 0);
    send(1'b1, 2'b00, 1'b1, 3, 10'h060, 10'h0A0, 16'hFFFF, 16);

    wait_ready();
    drive(1'b0, 2'b01, 1'b0, 8, 10'h100, 10'h200);
    a = cyc;
    push_expect(a, 1'b0, 2'b01, 1'b0, 8, 10'h100, 10'h200, 16'h0, 0, d1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 sys_rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    hs_q.delete();
    done_q.delete();
    win_q.delete();
    #1;
    check_eq("abort_ctl", {m_cb_ena, m_nl_ready, m_tb_ena, m_tb_wea, m_busy, m_done, m_lk, m_ready}, 8'h01);
    check_eq("abort_sel", m_sel, 0);
    repeat (2) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    check_eq("ready_release", m_ready, 1);
    repeat (12) @(posedge clk);

    use3 = 1'b1;
    send(1'b0, 2'b01, 1'b0, 4, 10'h3FD, 10'h3FE, 16'h0, 0);
    send(1'b0, 2'b11, 1'b1, 255, 10'h3F0, 10'h001, 16'h0, 0);
    use3 = 1'b0;
    send(1'b1, 2'b11, 1'b1, 255, 10'h000, 10'h3F8, 16'h5A5A, 16);

    repeat (5) @(posedge clk);
    check_eq("queues_empty", rd_q.size() + wr_q.size() + hs_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
